// File: rtl/processor_pkg.sv
// processor_pkg: shared constants and types for the 9-bit didactic processor.
//   DATA_WIDTH / NUM_REGS  : bus width and general register count
//   opcode_t               : defined opcodes (4..7 decode as NOP)
//   step_t                 : instruction sequencer step states
//   *_LSB / FIELD_W        : instruction field positions within IR
package processor_pkg;

   localparam int DATA_WIDTH = 9;
   localparam int NUM_REGS   = 8;

   localparam int OPC_LSB = 0;
   localparam int X_LSB   = 3;
   localparam int Y_LSB   = 6;
   localparam int FIELD_W = 3;

   typedef enum logic [FIELD_W-1:0] {
      OP_MOV  = 3'd0,
      OP_MOVI = 3'd1,
      OP_ADD  = 3'd2,
      OP_SUB  = 3'd3
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T1   = 2'd1,
      T2   = 2'd2,
      T3   = 2'd3
   } step_t;

endpackage

// File: rtl/reg_decoder_3to8.sv
// reg_decoder_3to8: register address to one-hot select.
//   addr_i   : register index
//   en_i     : when low the output is all zeros
//   onehot_o : one-hot (or zero) register select
module reg_decoder_3to8 #(
   parameter int ADDR_W = 3,
   parameter int OUT_W  = 8
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              en_i,
   output logic [OUT_W-1:0]  onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[addr_i] = 1'b1;
   end

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle control FSM for the 9-bit processor.
// Captures an instruction from DIN when Run is seen in IDLE, then steps
// through T1..T3 driving the shared-bus enables.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   Run, DIN     : start request / instruction word (immediate in movi T1)
//   IRin         : instruction register load strobe
//   Rout, Gout, DINout : bus drivers (mutually exclusive)
//   Rin, Ain, Gin      : register / A / G load enables
//   AddSub       : ALU op, 0 = add, 1 = subtract
//   Done, Busy   : final-step pulse / not-idle status
module instruction_sequencer
   import processor_pkg::*;
#(
   parameter int DATA_WIDTH = processor_pkg::DATA_WIDTH,
   parameter int NUM_REGS   = processor_pkg::NUM_REGS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  Run,
   input  logic [DATA_WIDTH-1:0] DIN,
   output logic                  IRin,
   output logic [NUM_REGS-1:0]   Rout,
   output logic                  Gout,
   output logic                  DINout,
   output logic [NUM_REGS-1:0]   Rin,
   output logic                  Ain,
   output logic                  Gin,
   output logic                  AddSub,
   output logic                  Done,
   output logic                  Busy
);

   step_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0] ir_q, ir_d;

   logic [FIELD_W-1:0] opc, fx, fy;
   logic               is_arith;

   logic               rout_en, rin_en;
   logic [FIELD_W-1:0] rout_addr, rin_addr;

   assign opc      = ir_q[OPC_LSB +: FIELD_W];
   assign fx       = ir_q[X_LSB +: FIELD_W];
   assign fy       = ir_q[Y_LSB +: FIELD_W];
   assign is_arith = (opc == OP_ADD) || (opc == OP_SUB);

   // IR only ever loads in IDLE, so DIN in later steps cannot disturb it
   assign ir_d = IRin ? DIN : ir_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Run) state_d = T1;
         T1:      state_d = is_arith ? T2 : IDLE;
         T2:      state_d = T3;
         T3:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Everything is gated by reset so the datapath sees no enables while
   // reset is held, whatever state/Run happen to be.
   always_comb begin
      IRin      = 1'b0;
      Gout      = 1'b0;
      DINout    = 1'b0;
      Ain       = 1'b0;
      Gin       = 1'b0;
      AddSub    = 1'b0;
      Done      = 1'b0;
      Busy      = 1'b0;
      rout_en   = 1'b0;
      rout_addr = '0;
      rin_en    = 1'b0;
      rin_addr  = '0;
      if (!reset) begin
         Busy = (state_q != IDLE);
         case (state_q)
            IDLE: IRin = Run;
            T1: begin
               case (opc)
                  OP_MOV: begin
                     rout_en = 1'b1; rout_addr = fy;
                     rin_en  = 1'b1; rin_addr  = fx;
                     Done    = 1'b1;
                  end
                  OP_MOVI: begin
                     DINout = 1'b1;
                     rin_en = 1'b1; rin_addr = fx;
                     Done   = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     rout_en = 1'b1; rout_addr = fx;
                     Ain     = 1'b1;
                  end
                  default: Done = 1'b1;  // reserved opcodes behave as NOP
               endcase
            end
            T2: begin
               rout_en = 1'b1; rout_addr = fy;
               Gin     = 1'b1;
               AddSub  = (opc == OP_SUB);
            end
            T3: begin
               Gout   = 1'b1;
               rin_en = 1'b1; rin_addr = fx;
               Done   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   reg_decoder_3to8 #(.ADDR_W(FIELD_W), .OUT_W(NUM_REGS)) u_rout_dec (
      .addr_i   (rout_addr),
      .en_i     (rout_en),
      .onehot_o (Rout)
   );

   reg_decoder_3to8 #(.ADDR_W(FIELD_W), .OUT_W(NUM_REGS)) u_rin_dec (
      .addr_i   (rin_addr),
      .en_i     (rin_en),
      .onehot_o (Rin)
   );

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Multi-cycle control FSM for the didactic 9-bit processor. It captures an instruction word from DIN and drives the per-cycle enables for the shared bus:

- mux select: register outputs, G output, DIN output
- register file write enables
- A and G register loads
- ALU add/sub select

It sits between the external Run/DIN inputs and the datapath (eight general registers, A, G, ALU, bus mux). It replaces ad-hoc enable wiring with a defined step sequence and a one-cycle Done pulse.

## Interface
Parameters:
- DATA_WIDTH, 9, instruction/bus word width; instruction fields occupy bits [8:0].
- NUM_REGS, 8, general registers; one-hot enable width.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  reset is synchronous and active-high.
- Run  input  1  start request, sampled only in IDLE.
- DIN  input  DATA_WIDTH  instruction word in IDLE; immediate operand in step T1 of movi.
- IRin  output  1  instruction register load strobe (visible to datapath/debug).
- Rout  output  NUM_REGS  one-hot register-to-bus select.
- Gout  output  1  G register drives bus.
- DINout  output  1  DIN drives bus.
- Rin  output  NUM_REGS  one-hot register write enable.
- Ain  output  1  load A from bus.
- Gin  output  1  load G from ALU result.
- AddSub  output  1  ALU op: 0 = A+bus, 1 = A−bus.
- Done  output  1  one-cycle pulse in the final step of an instruction.
- Busy  output  1  high in every state except IDLE.

## Operation
Instruction fields:
- DIN[2:0] opcode
- DIN[5:3] X (destination / first operand)
- DIN[8:6] Y (source)

Opcodes:
- 0 mov
- 1 movi
- 2 add
- 3 sub
- 4–7 reserved → NOP

The internal IR (DATA_WIDTH bits) loads DIN when IRin=1.

States are IDLE, T1, T2, T3.
- IDLE: IRin = Run. If Run, go to T1; else stay.
- T1:
  - mov: Rout=onehot(Y), Rin=onehot(X), Done. Next IDLE.
  - movi: DINout, Rin=onehot(X), Done. Next IDLE.
  - add/sub: Rout=onehot(X), Ain. Next T2.
  - NOP: Done only, no enables. Next IDLE.
- T2 (add/sub): Rout=onehot(Y), Gin, AddSub = (opcode==sub). Next T3.
- T3 (add/sub): Gout, Rin=onehot(X), Done. Next IDLE.

Rules:
- All outputs not listed for a state are 0.
- Invariant: at most one of {any Rout bit, Gout, DINout} is high in any cycle.
- Rin and Rout are each zero or one-hot.
- X==Y is legal:
  - mov Rx,Rx rewrites the same value.
  - add Rx,Rx doubles Rx.
- Run outside IDLE is ignored; there is no queuing.

## Timing
- Reset (synchronous, high at a rising edge):
  - next state IDLE, IR cleared to 0.
  - while reset is high, all outputs are forced to 0, IRin included, regardless of Run.
- Reset mid-instruction aborts with no Done. Writes already committed are not undone.
- All outputs are combinational decodes of (state, IR, Run). There is no output register; the datapath samples enables on the next edge.
- Latency, from the cycle Run is sampled high in IDLE to the cycle Done is high:
  - mov, movi, NOP: 1 cycle (Done in T1).
  - add, sub: 3 cycles (Done in T3).
- Back-to-back: in the cycle after Done, state is IDLE. If Run=1 there, the next instruction loads. Throughput is 2 cycles per mov and 4 per add.
- movi: DIN must hold the immediate during T1, i.e. exactly one cycle after the instruction cycle.
- Run held continuously high issues a new instruction every time IDLE is reached.

## Structure
- Package processor_pkg:
  - DATA_WIDTH and NUM_REGS constants
  - opcode_t enum (OP_MOV=0, OP_MOVI=1, OP_ADD=2, OP_SUB=3)
  - step_t state enum (IDLE, T1, T2, T3)
  - field slice localparams (OPC_LSB=0, X_LSB=3, Y_LSB=6, FIELD_W=3)
- Sub-module reg_decoder_3to8: 3-bit address plus enable → 8-bit one-hot. Instantiate twice, once for Rout and once for Rin.
- IR register and state register are local to instruction_sequencer.

## Test plan
- Reset then idle: reset=1 for 2 cycles with Run=1 → all outputs 0 and Busy=0. After release with Run=0, outputs stay 0.
- mov R2,R5 (DIN=9'h150, Run=1 one cycle) → cycle 0: IRin=1. Cycle 1: Rout=8'b0010_0000, Rin=8'b0000_0100, Done=1. Cycle 2: Busy=0.
- movi R3,#0x1A5 (9'h019, then DIN=9'h1A5) → cycle 1: DINout=1, Rin=8'b0000_1000, Done=1.
- add R1,R4 (9'h10A) → T1: Rout=8'h02, Ain. T2: Rout=8'h10, Gin, AddSub=0. T3: Gout, Rin=8'h02, Done. Run pulsed during T2 has no effect.
- sub R7,R0 (9'h03B) → T2 AddSub=1; T3 Rin=8'h80. Immediately followed by opcode 5 (9'h005) → T1 Done=1 with all enables 0.
- Reset asserted in T2 of an add → next cycle IDLE, no Done, no Rin. Bus-exclusivity and one-hot assertions hold across a 1000-instruction random run.
